// File: rtl/fetch_pair_unpacker_pkg.sv
// fetch_pair_unpacker_pkg: shared widths, FIFO entry layout and half-select states
package fetch_pair_unpacker_pkg;
    localparam int FETCH_W = 64;
    localparam int INST_W  = 32;
    typedef struct packed {
        logic [28:0]        pc_hi;
        logic               start_hi;
        logic [FETCH_W-1:0] inst;
        logic               error;
    } fetch_entry_t;
    typedef enum logic {LO, HI} half_t;
endpackage

// File: rtl/fetch_pair_unpacker_if.sv
// fetch_pair_unpacker_if: fetch-response input, instruction stream output and fill level
interface fetch_pair_unpacker_if #(parameter int PTR_W = 2);
    import fetch_pair_unpacker_pkg::*;
    logic               flush_i;
    logic               fetch_valid_i;
    logic               fetch_error_i;
    logic [FETCH_W-1:0] fetch_inst_i;
    logic [31:0]        fetch_pc_i;
    logic               fetch_accept_o;
    logic               inst_valid_o;
    logic [INST_W-1:0]  inst_o;
    logic [31:0]        inst_pc_o;
    logic               inst_error_o;
    logic               inst_ready_i;
    logic [PTR_W:0]     level_o;
    modport master (
        output flush_i, fetch_valid_i, fetch_error_i, fetch_inst_i, fetch_pc_i, inst_ready_i,
        input  fetch_accept_o, inst_valid_o, inst_o, inst_pc_o, inst_error_o, level_o
    );
    modport slave (
        input  flush_i, fetch_valid_i, fetch_error_i, fetch_inst_i, fetch_pc_i, inst_ready_i,
        output fetch_accept_o, inst_valid_o, inst_o, inst_pc_o, inst_error_o, level_o
    );
endinterface

// File: rtl/fetch_pair_unpacker_fifo_ram.sv
// fetch_pair_unpacker_fifo_ram: DEPTH entry registers, one write port, async read port
module fetch_pair_unpacker_fifo_ram
    import fetch_pair_unpacker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk_i,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  fetch_entry_t       wdata,
    input  logic [PTR_W-1:0]   raddr,
    output fetch_entry_t       rdata
);
    fetch_entry_t mem [DEPTH];
    always_ff @(posedge clk_i)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_pair_unpacker.sv
// fetch_pair_unpacker: buffers 64-bit fetch pairs and unpacks them into a 32-bit
// valid/ready instruction stream with PC, honouring odd-word starts, errors and flush.
module fetch_pair_unpacker
    import fetch_pair_unpacker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fetch_pair_unpacker_if.slave bus
);
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   level;
    half_t            state_q, state_d;
    fetch_entry_t     head, wdata;
    logic             valid, push, fire, half, pop;

    assign valid              = level != '0;
    assign bus.fetch_accept_o = level < (PTR_W+1)'(DEPTH);
    assign push               = bus.fetch_valid_i & bus.fetch_accept_o & ~bus.flush_i;
    assign fire               = valid & bus.inst_ready_i;
    // An odd-word start behaves as if the lower half was already consumed
    assign half               = (state_q == HI) | head.start_hi;
    assign pop                = fire & (half | head.error);
    assign wdata              = '{pc_hi: bus.fetch_pc_i[31:3], start_hi: bus.fetch_pc_i[2],
                                  inst: bus.fetch_inst_i, error: bus.fetch_error_i};

    fetch_pair_unpacker_fifo_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_comb begin
        state_d = (bus.flush_i | pop) ? LO : fire ? HI : state_q;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state_q <= LO;
        else       state_q <= state_d;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= bus.flush_i ? wr_ptr : rd_ptr + PTR_W'(pop);
            level  <= bus.flush_i ? '0 : level + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end

    assign bus.inst_valid_o = valid;
    assign bus.inst_error_o = valid & head.error;
    assign bus.inst_o       = (valid & ~head.error) ? (half ? head.inst[63:32] : head.inst[31:0]) : '0;
    assign bus.inst_pc_o    = valid ? {head.pc_hi, half, 2'b00} : '0;
    assign bus.level_o      = level;

    no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.fetch_valid_i |-> bus.fetch_accept_o);
endmodule

// File: tb/tb_fetch_pair_unpacker.sv
// tb_fetch_pair_unpacker: directed vectors with hand-computed expectations
module tb_fetch_pair_unpacker;
    logic clk = 0;
    logic rst = 1;
    int   vectors = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    fetch_pair_unpacker_if #(.PTR_W(2)) b();
    fetch_pair_unpacker #(.DEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .bus(b.slave));

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [63:0] inst, input logic err);
        b.fetch_valid_i = 1; b.fetch_pc_i = pc; b.fetch_inst_i = inst; b.fetch_error_i = err;
        tick();
        b.fetch_valid_i = 0; b.fetch_error_i = 0;
    endtask

    task automatic beat(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, b.inst_valid_o, 1);
        chk({tag, "_inst"},  b.inst_o, inst);
        chk({tag, "_pc"},    b.inst_pc_o, pc);
        chk({tag, "_err"},   b.inst_error_o, 0);
    endtask

    function automatic logic [31:0] lo_w(input int k); return 32'h1111_0000 + 32'(2*k); endfunction
    function automatic logic [31:0] hi_w(input int k); return 32'h1111_0001 + 32'(2*k); endfunction
    function automatic logic [31:0] pc_k(input int k); return 32'h8000_0020 + 32'(8*k); endfunction

    initial begin
        b.flush_i = 0; b.fetch_valid_i = 0; b.fetch_error_i = 0;
        b.fetch_inst_i = '0; b.fetch_pc_i = '0; b.inst_ready_i = 0;
        #3;
        chk("rst_accept", b.fetch_accept_o, 1);
        chk("rst_valid",  b.inst_valid_o, 0);
        chk("rst_inst",   b.inst_o, 0);
        chk("rst_pc",     b.inst_pc_o, 0);
        chk("rst_err",    b.inst_error_o, 0);
        chk("rst_level",  b.level_o, 0);
        rst = 0;
        tick();

        // aligned pair: lower then upper word, one cycle after push
        b.fetch_valid_i = 1; b.fetch_pc_i = 32'h8000_0000; b.fetch_inst_i = 64'h00000013_00100093;
        chk("t1_nobypass", b.inst_valid_o, 0);
        tick();
        b.fetch_valid_i = 0;
        beat("t1_lo", 32'h8000_0000, 32'h0010_0093);
        chk("t1_level_a", b.level_o, 1);
        b.inst_ready_i = 1;
        tick();
        beat("t1_hi", 32'h8000_0004, 32'h0000_0013);
        chk("t1_level_b", b.level_o, 1);
        tick();
        chk("t1_empty", b.inst_valid_o, 0);
        chk("t1_level_c", b.level_o, 0);
        b.inst_ready_i = 0;

        // odd-word start emits only the upper word
        push(32'h8000_0004, 64'hAAAAAAAA_BBBBBBBB, 0);
        beat("t2_hi", 32'h8000_0004, 32'hAAAA_AAAA);
        b.inst_ready_i = 1;
        tick();
        chk("t2_empty", b.inst_valid_o, 0);
        chk("t2_level", b.level_o, 0);
        b.inst_ready_i = 0;

        // fill to full, backpressure, then ordered drain across pointer wrap
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                chk("t3_accept_l3", b.fetch_accept_o, 1);
                chk("t3_level_3", b.level_o, 3);
            end
            push(pc_k(k), {hi_w(k), lo_w(k)}, 0);
        end
        chk("t3_accept_full", b.fetch_accept_o, 0);
        chk("t3_level_full", b.level_o, 4);
        beat("t3_lo0", pc_k(0), lo_w(0));
        tick();
        beat("t3_hold", pc_k(0), lo_w(0));
        b.inst_ready_i = 1;
        tick();
        beat("t3_hi0", pc_k(0) + 4, hi_w(0));
        chk("t3_accept_stillfull", b.fetch_accept_o, 0);
        tick();
        chk("t3_accept_back", b.fetch_accept_o, 1);
        chk("t3_level_after_pop", b.level_o, 3);
        for (int k = 1; k < 4; k++) begin
            beat($sformatf("t3_lo%0d", k), pc_k(k), lo_w(k));
            tick();
            beat($sformatf("t3_hi%0d", k), pc_k(k) + 4, hi_w(k));
            if (k == 1) begin
                b.fetch_valid_i = 1; b.fetch_pc_i = pc_k(4); b.fetch_inst_i = {hi_w(4), lo_w(4)};
            end
            tick();
            b.fetch_valid_i = 0;
            if (k == 1) chk("t3_pushpop_level", b.level_o, 3);
        end
        beat("t3_lo4", pc_k(4), lo_w(4));
        tick();
        beat("t3_hi4", pc_k(4) + 4, hi_w(4));
        tick();
        chk("t3_empty", b.inst_valid_o, 0);
        chk("t3_level_end", b.level_o, 0);
        b.inst_ready_i = 0;

        // error entry: one beat, inst forced to zero
        push(32'h8000_0010, 64'hFFFFFFFF_FFFFFFFF, 1);
        chk("t4_valid", b.inst_valid_o, 1);
        chk("t4_err",   b.inst_error_o, 1);
        chk("t4_inst",  b.inst_o, 0);
        chk("t4_pc",    b.inst_pc_o, 32'h8000_0010);
        b.inst_ready_i = 1;
        tick();
        chk("t4_empty", b.inst_valid_o, 0);
        chk("t4_err_clr", b.inst_error_o, 0);
        chk("t4_level", b.level_o, 0);
        b.inst_ready_i = 0;

        // flush with a concurrent push drops everything
        push(32'h8000_0200, 64'h1_00000002, 0);
        push(32'h8000_0208, 64'h3_00000004, 0);
        push(32'h8000_0210, 64'h5_00000006, 0);
        chk("t5_level_3", b.level_o, 3);
        b.flush_i = 1; b.fetch_valid_i = 1;
        b.fetch_pc_i = 32'h8000_0300; b.fetch_inst_i = 64'hDEADBEEF_CAFEF00D;
        tick();
        b.flush_i = 0; b.fetch_valid_i = 0;
        chk("t5_valid", b.inst_valid_o, 0);
        chk("t5_level", b.level_o, 0);
        chk("t5_accept", b.fetch_accept_o, 1);
        push(32'h8000_0400, 64'h55555555_66666666, 0);
        beat("t5_next_lo", 32'h8000_0400, 32'h6666_6666);
        chk("t5_next_level", b.level_o, 1);
        b.inst_ready_i = 1;
        tick();
        beat("t5_next_hi", 32'h8000_0404, 32'h5555_5555);
        tick();
        chk("t5_drained", b.level_o, 0);
        b.inst_ready_i = 0;

        // async reset mid-drain, then restart from the lower half
        push(32'h8000_0500, 64'h12345678_9ABCDEF0, 0);
        push(32'h8000_0508, 64'h0FEDCBA9_87654321, 0);
        b.inst_ready_i = 1;
        tick();
        beat("t6_mid_hi", 32'h8000_0504, 32'h1234_5678);
        #2 rst = 1;
        #1;
        chk("t6_rst_valid",  b.inst_valid_o, 0);
        chk("t6_rst_inst",   b.inst_o, 0);
        chk("t6_rst_pc",     b.inst_pc_o, 0);
        chk("t6_rst_level",  b.level_o, 0);
        chk("t6_rst_accept", b.fetch_accept_o, 1);
        b.inst_ready_i = 0;
        tick();
        rst = 0;
        push(32'h8000_0100, 64'h77778888_99990000, 0);
        beat("t6_lo", 32'h8000_0100, 32'h9999_0000);
        b.inst_ready_i = 1;
        tick();
        beat("t6_hi", 32'h8000_0104, 32'h7777_8888);
        tick();
        chk("t6_empty", b.inst_valid_o, 0);
        chk("t6_level", b.level_o, 0);
        b.inst_ready_i = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
